// File: rtl/common_types_pkg.sv
// Shared types for the branch prediction unit: PHT indexing mode and the
// performance counter width.
package common_types_pkg;

    typedef enum logic {
        BP_BIMODAL,
        BP_GSHARE
    } bp_mode_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a W-bit saturating up/down counter; holds at both ends
// and when neither or both directions are requested.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_value,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_next
);

    always_comb begin
        o_next = i_value;
        if (i_inc && !i_dec && (i_value != {W{1'b1}})) begin
            o_next = i_value + 1'b1;
        end else if (i_dec && !i_inc && (i_value != {W{1'b0}})) begin
            o_next = i_value - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: PHT of saturating counters, tagged BTB,
// speculative GHR with mispredict repair and saturating perf counters.
module branch_predictor_gshare
    import common_types_pkg::*;
#(
    parameter int       PHT_BITS = 10,
    parameter int       CTR_BITS = 2,
    parameter int       GHR_BITS = 8,
    parameter int       BTB_BITS = 8,
    parameter int       TAG_BITS = 10,
    parameter bp_mode_t MODE     = BP_GSHARE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    output logic                fetch_predict,
    output logic [31:0]         fetch_target,
    output logic [GHR_BITS-1:0] fetch_ghr,
    input  logic                mem_branch,
    input  logic [31:0]         mem_pc,
    input  logic                mem_taken,
    input  logic [31:0]         mem_target_res,
    input  logic                mem_predict,
    input  logic [31:0]         mem_target,
    input  logic [GHR_BITS-1:0] mem_ghr,
    output logic                mem_flush,
    output logic                mem_branch_miss,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_misses
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    logic [CTR_BITS-1:0] r_pht [PHT_ENTRIES];
    btb_entry_t          r_btb [BTB_ENTRIES];
    logic [GHR_BITS-1:0] r_ghr;
    logic [PERF_W-1:0]   r_perfBranches;
    logic [PERF_W-1:0]   r_perfMisses;

    logic [PHT_BITS-1:0] w_fetchPhtIdx;
    logic [PHT_BITS-1:0] w_memPhtIdx;
    logic [BTB_BITS-1:0] w_fetchBtbIdx;
    logic [BTB_BITS-1:0] w_memBtbIdx;
    logic [TAG_BITS-1:0] w_fetchTag;
    logic [TAG_BITS-1:0] w_memTag;
    btb_entry_t          w_fetchEntry;
    btb_entry_t          w_memEntry;
    logic [CTR_BITS-1:0] w_fetchCtr;
    logic [CTR_BITS-1:0] w_memCtr;
    logic [CTR_BITS-1:0] w_phtNext;
    logic                w_fetchHit;
    logic                w_memMiss;
    logic                w_aliasInvalidate;
    logic [GHR_BITS-1:0] w_ghrSpec;
    logic [GHR_BITS-1:0] w_ghrRepair;
    logic [PERF_W-1:0]   w_perfBranchesNext;
    logic [PERF_W-1:0]   w_perfMissesNext;
    logic                w_unused;

    // In bimodal mode the history term is forced to zero so only the PC indexes.
    function automatic logic [PHT_BITS-1:0] phtIndex(input logic [31:0]         pc,
                                                     input logic [GHR_BITS-1:0] ghr);
        return pc[PHT_BITS+1:2] ^ ((MODE == BP_GSHARE) ? PHT_BITS'(ghr) : {PHT_BITS{1'b0}});
    endfunction

    assign w_fetchPhtIdx = phtIndex(fetch_pc, r_ghr);
    assign w_memPhtIdx   = phtIndex(mem_pc, mem_ghr);
    assign w_fetchBtbIdx = fetch_pc[BTB_BITS+1:2];
    assign w_memBtbIdx   = mem_pc[BTB_BITS+1:2];
    assign w_fetchTag    = fetch_pc[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
    assign w_memTag      = mem_pc[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
    assign w_fetchEntry  = r_btb[w_fetchBtbIdx];
    assign w_memEntry    = r_btb[w_memBtbIdx];
    assign w_fetchCtr    = r_pht[w_fetchPhtIdx];
    assign w_memCtr      = r_pht[w_memPhtIdx];

    assign w_fetchHit    = w_fetchEntry.valid && (w_fetchEntry.tag == w_fetchTag);
    assign fetch_predict = w_fetchHit && w_fetchCtr[CTR_BITS-1];
    assign fetch_target  = w_fetchHit ? w_fetchEntry.target : 32'h0;
    assign fetch_ghr     = r_ghr;

    // A non-branch can only "miss" because a stale BTB hit made fetch predict it.
    always_comb begin
        w_memMiss = mem_predict;
        if (mem_branch) begin
            w_memMiss = (mem_predict != mem_taken) ||
                        (mem_predict && mem_taken && (mem_target != mem_target_res));
        end
    end

    assign mem_flush         = w_memMiss;
    assign mem_branch_miss   = w_memMiss;
    assign w_aliasInvalidate = !mem_branch && mem_predict && w_memEntry.valid &&
                               (w_memEntry.tag == w_memTag);

    assign w_ghrSpec   = GHR_BITS'({r_ghr, fetch_predict});
    assign w_ghrRepair = mem_branch ? GHR_BITS'({mem_ghr, mem_taken}) : mem_ghr;

    assign perf_branches = r_perfBranches;
    assign perf_misses   = r_perfMisses;

    // Only the index and tag fields of the PCs feed the tables.
    assign w_unused = ^{fetch_pc, mem_pc};

    sat_counter #(.W(CTR_BITS)) u_phtCtr (
        .i_value (w_memCtr),
        .i_inc   (mem_taken),
        .i_dec   (!mem_taken),
        .o_next  (w_phtNext)
    );

    sat_counter #(.W(PERF_W)) u_perfBranches (
        .i_value (r_perfBranches),
        .i_inc   (mem_branch),
        .i_dec   (1'b0),
        .o_next  (w_perfBranchesNext)
    );

    sat_counter #(.W(PERF_W)) u_perfMisses (
        .i_value (r_perfMisses),
        .i_inc   (w_memMiss),
        .i_dec   (1'b0),
        .o_next  (w_perfMissesNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (mem_branch) begin
            r_pht[w_memPhtIdx] <= w_phtNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (mem_branch && mem_taken) begin
            r_btb[w_memBtbIdx] <= {1'b1, w_memTag, mem_target_res};
        end else if (w_aliasInvalidate) begin
            r_btb[w_memBtbIdx].valid <= 1'b0;
        end
    end

    // Repair from the mem-stage snapshot overrides any speculative shift this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_memMiss) begin
            r_ghr <= w_ghrRepair;
        end else if (fetch_valid && w_fetchHit) begin
            r_ghr <= w_ghrSpec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfBranches <= '0;
            r_perfMisses   <= '0;
        end else begin
            r_perfBranches <= w_perfBranchesNext;
            r_perfMisses   <= w_perfMissesNext;
        end
    end

endmodule
